// File: rtl/mem_burst_master_if.sv
// Bundle of command, write-data, read-data and memory-side signals for mem_burst_master.
// "master" is the burst engine's view; "slave" is the view of whatever drives and serves it.
interface mem_burst_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    logic              busy;

    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datai;
    logic [DATA_W-1:0] mem_datao;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  mem_datao,
        output cmd_ready, wr_ready,
        output rd_valid, rd_data, rd_last,
        output busy,
        output mem_ce, mem_we, mem_addr, mem_datai
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        output mem_datao,
        input  cmd_ready, wr_ready,
        input  rd_valid, rd_data, rd_last,
        input  busy,
        input  mem_ce, mem_we, mem_addr, mem_datai
    );
endinterface

// File: rtl/mem_burst_master.sv
// Burst engine turning write/read burst commands into single-cycle memory accesses,
// with a 2-entry read FIFO absorbing the one-cycle memory read latency.
module mem_burst_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    mem_burst_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // One extra bit so a zero length loads as 2^ADDR_W beats.
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              inflight_q, inflight_d;
    logic              infl_last_q, infl_last_d;

    logic [DATA_W-1:0] fifo_data_q [2];
    logic [1:0]        fifo_last_q;
    logic              rptr_q, wptr_q;
    logic [1:0]        occ_q, occ_d;

    logic              fifo_valid;
    logic              push;
    logic              pop;
    logic [2:0]        level;
    logic              last_beat;

    assign fifo_valid = (occ_q != 2'd0) && !reset;
    assign push       = inflight_q && !reset;
    assign pop        = fifo_valid && bus.rd_ready;
    assign last_beat  = (cnt_q == (ADDR_W+1)'(1));
    // Entries that will be held once this cycle's pop and any new issue settle.
    assign level      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

    assign bus.rd_valid = fifo_valid;
    assign bus.rd_data  = fifo_data_q[rptr_q];
    assign bus.rd_last  = fifo_valid && fifo_last_q[rptr_q];
    assign bus.busy     = (state_q != IDLE) && !reset;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        inflight_d    = 1'b0;
        infl_last_d   = infl_last_q;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.mem_ce    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = addr_q;
        bus.mem_datai = '0;

        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    cnt_d   = {bus.cmd_len == '0, bus.cmd_len};
                    state_d = bus.cmd_we ? WRITE : READ;
                end
            end
            WRITE: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    bus.mem_ce    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_datai = bus.wr_data;
                    addr_d        = addr_q + 1'b1;
                    cnt_d         = cnt_q - 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                if (cnt_q != '0 && level < 3'd2) begin
                    bus.mem_ce  = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    inflight_d  = 1'b1;
                    infl_last_d = last_beat;
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (occ_q == 2'd0 && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        occ_d = occ_q + 2'(push) - 2'(pop);

        // Reset silences the handshakes and the memory port in the same cycle.
        if (reset) begin
            bus.cmd_ready = 1'b0;
            bus.wr_ready  = 1'b0;
            bus.mem_ce    = 1'b0;
            bus.mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= 2'd0;
            rptr_q      <= 1'b0;
            wptr_q      <= 1'b0;
            fifo_last_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            occ_q       <= occ_d;
            rptr_q      <= rptr_q ^ pop;
            wptr_q      <= wptr_q ^ push;
            if (push) begin
                fifo_last_q[wptr_q] <= infl_last_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wptr_q] <= bus.mem_datao;
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboarded bench for mem_burst_master: directed bursts against a behavioural memory,
// with a monitor checking every memory write and every popped read beat.
module tb_mem_burst_master;

    logic clk;
    logic reset;

    mem_burst_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_burst_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_wr [$];   // {addr, data}
    logic [8:0]  exp_rd [$];   // {last, data}
    int          outstanding = 0;
    logic [7:0]  mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory returns garbage whenever no read was issued, so a stray capture shows up.
    always @(posedge clk) begin
        if (bus.mem_ce && bus.mem_we) mem[bus.mem_addr] <= bus.mem_datai;
        if (bus.mem_ce && !bus.mem_we) bus.mem_datao <= mem[bus.mem_addr];
        else bus.mem_datao <= 8'($urandom);
    end

    always @(negedge clk) begin
        logic [15:0] ew;
        logic [8:0]  er;
        int          popn;
        if (reset) begin
            chk("rst_mem_ce", bus.mem_ce, 0);
            outstanding = 0;
        end else begin
            if (bus.mem_ce && bus.mem_we) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    ew = exp_wr.pop_front();
                    chk("wr_addr", bus.mem_addr, ew[15:8]);
                    chk("wr_data", bus.mem_datai, ew[7:0]);
                end
            end
            popn = (bus.rd_valid && bus.rd_ready) ? 1 : 0;
            if (popn == 1) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    er = exp_rd.pop_front();
                    chk("rd_data", bus.rd_data, er[7:0]);
                    chk("rd_last", bus.rd_last, er[8]);
                end
            end
            if (bus.mem_ce && !bus.mem_we) begin
                chk("rd_credit", (outstanding - popn) < 2, 1);
                outstanding = outstanding + 1;
            end
            outstanding = outstanding - popn;
        end
    end

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (bus.busy && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(name, bus.busy, 0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] len, input logic [7:0] d0,
                            input bit gaps);
        int beats = (len == 0) ? 256 : int'(len);
        int sent = 0;
        int cyc = 0;
        for (int i = 0; i < beats; i++) exp_wr.push_back({8'(a + 8'(i)), 8'(d0 + 8'(i))});
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = a; bus.cmd_len = len;
        @(negedge clk);
        chk("wr_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;
        // With gaps, keep offering a read command that must be ignored.
        bus.cmd_valid = gaps; bus.cmd_we = 1'b0; bus.cmd_addr = 8'h55; bus.cmd_len = 8'h01;
        while (sent < beats && cyc < 2000) begin
            bus.wr_valid = !(gaps && (cyc % 3 == 2));
            bus.wr_data  = 8'(d0 + 8'(sent));
            @(negedge clk);
            if (gaps) chk("wr_cmd_ignored", bus.cmd_ready, 0);
            if (!bus.wr_valid) chk("wr_gap_ce", bus.mem_ce, 0);
            if (bus.wr_valid && bus.wr_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.wr_valid = 1'b0; bus.cmd_valid = 1'b0;
        chk("wr_beats", sent, beats);
        if (!gaps) chk("wr_latency", cyc, beats);
        @(negedge clk);
        chk("wr_idle", bus.busy, 0);
        chk("wr_sb_empty", exp_wr.size(), 0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] len, input logic [7:0] d0,
                           input bit rnd);
        int beats = (len == 0) ? 256 : int'(len);
        int cyc = 0;
        for (int i = 0; i < beats; i++) exp_rd.push_back({i == beats - 1, 8'(d0 + 8'(i))});
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = a; bus.cmd_len = len;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        chk("rd_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (!rnd) begin
            @(negedge clk); chk("rd_lat_e0", bus.rd_valid, 0);
            @(negedge clk); chk("rd_lat_e1", bus.rd_valid, 0);
            for (int i = 0; i < beats; i++) begin
                @(negedge clk); chk("rd_stream", bus.rd_valid, 1);
            end
        end else begin
            while (exp_rd.size() != 0 && cyc < 500) begin
                bus.rd_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                cyc++;
            end
            bus.rd_ready = 1'b1;
        end
        @(posedge clk); #1;
        wait_idle("rd_idle");
        chk("rd_sb_empty", exp_rd.size(), 0);
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        do_write(8'h10, 8'd4, 8'hA0, 1'b0);
        do_read (8'h10, 8'd4, 8'hA0, 1'b0);

        do_write(8'hFE, 8'd3, 8'hC0, 1'b0);
        do_read (8'hFE, 8'd3, 8'hC0, 1'b0);

        do_write(8'h40, 8'd8, 8'h30, 1'b0);
        do_read (8'h40, 8'd8, 8'h30, 1'b1);

        // Stall a read with a full FIFO, then reset in the middle of it.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 8'h40; bus.cmd_len = 8'd8;
        bus.rd_ready = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_rd_valid", bus.rd_valid, 1);
        chk("stall_no_issue", bus.mem_ce, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_rd_valid", bus.rd_valid, 0);
        chk("midrst_mem_ce", bus.mem_ce, 0);
        chk("midrst_busy", bus.busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_fifo_empty", bus.rd_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_quiet_ce", bus.mem_ce, 0);

        do_write(8'h00, 8'd0, 8'h00, 1'b1);
        do_read (8'h05, 8'd2, 8'h05, 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the memory address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the memory data width.
REQ-003 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 cmd_valid  input  1  SHALL indicate a burst command is offered.
REQ-006 cmd_ready  output  1  SHALL indicate a command is accepted this cycle.
REQ-007 cmd_we  input  1  SHALL select the burst type: 1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_W  SHALL give the burst start address.
REQ-009 cmd_len  input  ADDR_W  SHALL give the beat count; 0 means 2^ADDR_W beats.
REQ-010 wr_valid / wr_ready  input / output  1 each  SHALL form the write-data handshake.
REQ-011 wr_data  input  DATA_W  SHALL carry the write beat.
REQ-012 rd_valid / rd_ready  output / input  1 each  SHALL form the read-data handshake.
REQ-013 rd_data  output  DATA_W  SHALL carry the read beat.
REQ-014 rd_last  output  1  SHALL mark the final read beat of a burst.
REQ-015 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-016 mem_ce, mem_we  output  1 each  SHALL drive memory chip enable and write enable.
REQ-017 mem_addr  output  ADDR_W; mem_datai  output  DATA_W  SHALL drive memory address and write data.
REQ-018 mem_datao  input  DATA_W  SHALL be memory read data, valid one cycle after a read access (ce=1, we=0).

Function
REQ-019 FSM SHALL have states IDLE, WRITE, READ, DRAIN.
REQ-020 IDLE: cmd_ready SHALL be 1; on cmd_valid, latch addr and beat count, go to WRITE if cmd_we else READ.
REQ-021 In all non-IDLE states, cmd_ready SHALL be 0; offered commands are not consumed.
REQ-022 WRITE: wr_ready SHALL be 1; each cycle with wr_valid: mem_ce=1, mem_we=1, mem_addr=current address, mem_datai=wr_data (combinational pass-through).
REQ-023 WRITE with wr_valid=0 SHALL stall: mem_ce=0, address and count unchanged.
REQ-024 After each accepted beat, the address SHALL increment modulo 2^ADDR_W (0xFF -> 0x00 at default width).
REQ-025 After the last write beat is accepted, the FSM SHALL go to IDLE on the next edge; write burst latency = beats cycles with no stalls.
REQ-026 READ: a read access SHALL be issued (mem_ce=1, mem_we=0) when beats remain and occupancy + inflight - pop < 2, where pop = rd_valid & rd_ready.
REQ-027 Read data SHALL be captured from mem_datao in the cycle after issue into a 2-entry output FIFO; mem_datao SHALL be ignored when no read is inflight.
REQ-028 rd_valid SHALL equal FIFO not-empty; rd_data SHALL be the FIFO head; pop SHALL occur on rd_valid & rd_ready.
REQ-029 When rd_ready is held high, read throughput SHALL be 1 beat/cycle; first rd_valid SHALL occur 2 cycles after command acceptance.
REQ-030 rd_ready low SHALL stall issue per REQ-026; no beat SHALL be lost or duplicated.
REQ-031 After the last read is issued: FSM SHALL enter DRAIN and go to IDLE the cycle after the FIFO is empty and nothing is inflight.
REQ-032 rd_last SHALL be 1 exactly when the FIFO head is the burst's final beat.
REQ-033 In READ/DRAIN, wr_ready SHALL be 0 and wr_data ignored; rd_ready with FIFO empty SHALL have no effect.
REQ-034 Outside accesses, mem_ce SHALL be 0; mem_we SHALL be 0 unless in a write access.

Reset
REQ-035 While reset=1: state IDLE, FIFO empty, inflight 0, address/count 0; mem_ce=0, mem_we=0, rd_valid=0, rd_last=0, wr_ready=0, cmd_ready=0, busy=0.
REQ-036 cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-037 Reset mid-burst SHALL abandon the burst, discard FIFO contents and any inflight read, and issue no further memory access.

Verification
REQ-038 Write burst addr=0x10 len=4 data 0xA0..0xA3, wr_valid always 1 -> 4 consecutive writes to 0x10..0x13, IDLE after 4 cycles.
REQ-039 Read back addr=0x10 len=4, rd_ready=1 -> rd_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, first 2 cycles after accept, rd_last on 0xA3.
REQ-040 Write addr=0xFE len=3 then read back -> accesses at 0xFE,0xFF,0x00; data returned in order.
REQ-041 Read len=8 with rd_ready toggled randomly -> exactly 8 beats in order, never more than 2 buffered, no mem_ce when FIFO plus inflight is full.
REQ-042 len=0 write with wr_valid gaps -> 256 writes, mem_ce=0 during every gap, cmd_valid during burst ignored.
REQ-043 reset asserted mid read burst -> next cycle rd_valid=0, mem_ce=0; cmd_ready=1 the cycle after reset deasserts.
